// File: rtl/adc_readout_ctrl.sv
// adc_readout_ctrl
//   Sequences a 12-bit monitoring ADC. A START request raises ADC_SOC for
//   SOC_CYCLES clocks. The controller then waits for the (synchronized)
//   falling edge of ADC_EOC_B, lets the ADC output settle for SETTLE_CYCLES
//   clocks and captures ADC_OUT. If no end-of-conversion arrives within
//   TIMEOUT_CYCLES, the conversion is aborted with a TIMEOUT pulse.
//
//   Optional feature macro: ADC_READOUT_AVG_EN
//     defined   : 2^AVG_SEL conversions (1/2/4/8) are summed in a 15-bit
//                 accumulator and the truncated average is reported.
//     undefined : AVG_SEL is ignored; one conversion, DATA = captured ADC_OUT.
//
//   Ports
//     CLOCK       in   rising-edge clock
//     RESET_B     in   synchronous active-low reset
//     START       in   conversion request (ignored while BUSY)
//     AVG_SEL     in   log2 of conversions per result (averaging build only)
//     ADC_SOC     out  start-of-conversion to the ADC
//     ADC_EOC_B   in   end-of-conversion from the ADC, active-low, asynchronous
//     ADC_OUT     in   ADC result, stable while ADC_EOC_B is low
//     BUSY        out  high whenever the FSM is not in IDLE
//     DATA        out  last completed result
//     DATA_VALID  out  one-cycle pulse when DATA updates
//     TIMEOUT     out  one-cycle pulse when a conversion is aborted
module adc_readout_ctrl #(
  parameter int unsigned SOC_CYCLES     = 64,
  parameter int unsigned SETTLE_CYCLES  = 2,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'hFFFF
) (
  input  logic        CLOCK,
  input  logic        RESET_B,
  input  logic        START,
  input  logic [1:0]  AVG_SEL,
  output logic        ADC_SOC,
  input  logic        ADC_EOC_B,
  input  logic [11:0] ADC_OUT,
  output logic        BUSY,
  output logic [11:0] DATA,
  output logic        DATA_VALID,
  output logic        TIMEOUT
);

  typedef enum logic [2:0] {IDLE, SOC, WAIT_EOC, SETTLE, CAPTURE} state_t;

  localparam logic [7:0]  SOC_LAST    = 8'(SOC_CYCLES - 1);
  localparam logic [15:0] TO_LAST     = TIMEOUT_CYCLES - 16'd1;
  localparam logic        SETTLE_SKIP = (SETTLE_CYCLES == 0);
  localparam logic [3:0]  SETTLE_LAST = 4'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);

  state_t      state;
  // [0] first sync flop, [1] second sync flop, [2] previous synchronized value
  logic [2:0]  eoc_sync;
  logic        eoc_fall;
  logic        eoc_latched;
  logic [7:0]  soc_cnt;
  logic [15:0] wait_cnt;
  logic [3:0]  settle_cnt;
  logic        done;

`ifdef ADC_READOUT_AVG_EN
  logic [1:0]  avg_q;
  logic [3:0]  conv_cnt;
  logic [14:0] acc;

  function automatic logic [11:0] avg_result(input logic [14:0] sum, input logic [1:0] sh);
    return 12'(sum >> sh);
  endfunction

  function automatic logic more_conv(input logic [3:0] finished, input logic [1:0] sh);
    return finished < (4'd1 << sh);
  endfunction
`else
  logic [11:0] cap;
  logic        unused_avg_sel;
  assign unused_avg_sel = &{1'b0, AVG_SEL};
`endif

  assign eoc_fall = !eoc_sync[1] && eoc_sync[2];

  always_ff @(posedge CLOCK) begin
    if (!RESET_B) begin
      state       <= IDLE;
      eoc_sync    <= 3'b111;
      eoc_latched <= 1'b0;
      soc_cnt     <= '0;
      wait_cnt    <= '0;
      settle_cnt  <= '0;
      done        <= 1'b0;
      ADC_SOC     <= 1'b0;
      BUSY        <= 1'b0;
      DATA        <= 12'h000;
      DATA_VALID  <= 1'b0;
      TIMEOUT     <= 1'b0;
`ifdef ADC_READOUT_AVG_EN
      avg_q       <= '0;
      conv_cnt    <= '0;
      acc         <= '0;
`else
      cap         <= '0;
`endif
    end else begin
      eoc_sync   <= {eoc_sync[1:0], ADC_EOC_B};
      DATA_VALID <= 1'b0;
      TIMEOUT    <= 1'b0;
      case (state)
        IDLE: begin
          // Result of the previous CAPTURE is published one cycle after it.
          if (done) begin
`ifdef ADC_READOUT_AVG_EN
            DATA <= avg_result(acc, avg_q);
`else
            DATA <= cap;
`endif
            DATA_VALID <= 1'b1;
            done       <= 1'b0;
          end
          if (START) begin
            state       <= SOC;
            ADC_SOC     <= 1'b1;
            BUSY        <= 1'b1;
            soc_cnt     <= '0;
            eoc_latched <= 1'b0;
`ifdef ADC_READOUT_AVG_EN
            avg_q       <= AVG_SEL;
            conv_cnt    <= '0;
            acc         <= '0;
`endif
          end
        end
        SOC: begin
          // An early EOC edge during SOC must not be lost.
          if (eoc_fall) eoc_latched <= 1'b1;
          if (soc_cnt == SOC_LAST) begin
            ADC_SOC  <= 1'b0;
            wait_cnt <= '0;
            state    <= WAIT_EOC;
          end else begin
            soc_cnt <= soc_cnt + 8'd1;
          end
        end
        WAIT_EOC: begin
          if (eoc_fall || eoc_latched) begin
            eoc_latched <= 1'b0;
            settle_cnt  <= '0;
            state       <= SETTLE_SKIP ? CAPTURE : SETTLE;
          end else if (wait_cnt == TO_LAST) begin
            TIMEOUT <= 1'b1;
            BUSY    <= 1'b0;
            state   <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) state <= CAPTURE;
          else settle_cnt <= settle_cnt + 4'd1;
        end
        CAPTURE: begin
`ifdef ADC_READOUT_AVG_EN
          acc      <= acc + {3'b000, ADC_OUT};
          conv_cnt <= conv_cnt + 4'd1;
          if (more_conv(conv_cnt + 4'd1, avg_q)) begin
            state       <= SOC;
            ADC_SOC     <= 1'b1;
            soc_cnt     <= '0;
            eoc_latched <= 1'b0;
          end else begin
            state <= IDLE;
            BUSY  <= 1'b0;
            done  <= 1'b1;
          end
`else
          cap   <= ADC_OUT;
          state <= IDLE;
          BUSY  <= 1'b0;
          done  <= 1'b1;
`endif
        end
        default: begin
          state   <= IDLE;
          ADC_SOC <= 1'b0;
          BUSY    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_readout_ctrl.sv
// Testbench for adc_readout_ctrl: directed scenarios against a simple ADC
// model that releases ADC_EOC_B high on each SOC rise and pulls it low with
// the next queued value three clocks after SOC falls.
module tb_adc_readout_ctrl;

  logic        CLOCK = 1'b0;
  logic        RESET_B = 1'b0;
  logic        START = 1'b0;
  logic [1:0]  AVG_SEL = 2'd0;
  logic        ADC_SOC;
  logic        ADC_EOC_B = 1'b1;
  logic [11:0] ADC_OUT = 12'h000;
  logic        BUSY;
  logic [11:0] DATA;
  logic        DATA_VALID;
  logic        TIMEOUT;

  adc_readout_ctrl #(
    .SOC_CYCLES(64),
    .SETTLE_CYCLES(2),
    .TIMEOUT_CYCLES(16'd100)
  ) dut (
    .CLOCK(CLOCK),
    .RESET_B(RESET_B),
    .START(START),
    .AVG_SEL(AVG_SEL),
    .ADC_SOC(ADC_SOC),
    .ADC_EOC_B(ADC_EOC_B),
    .ADC_OUT(ADC_OUT),
    .BUSY(BUSY),
    .DATA(DATA),
    .DATA_VALID(DATA_VALID),
    .TIMEOUT(TIMEOUT)
  );

  always #5 CLOCK = ~CLOCK;

`ifdef ADC_READOUT_AVG_EN
  localparam int          AVG_PULSES = 4;
  localparam logic [11:0] AVG_DATA   = 12'd101;  // (100+101+102+103) >> 2
`else
  localparam int          AVG_PULSES = 1;
  localparam logic [11:0] AVG_DATA   = 12'd100;
`endif

  int total = 0;
  int bad = 0;

  logic [11:0] vals [8];
  int          vidx = 0;
  bit          adc_respond = 1'b1;

  // ADC model
  initial begin
    forever begin
      @(posedge ADC_SOC);
      ADC_EOC_B = 1'b1;
      @(negedge ADC_SOC);
      if (adc_respond) begin
        repeat (3) @(posedge CLOCK);
        #2;
        ADC_OUT   = vals[vidx & 7];
        vidx      = vidx + 1;
        ADC_EOC_B = 1'b0;
      end
    end
  end

  // Event monitor, sampled on the falling edge
  int cyc = 0, soc_hi = 0, soc_pulses = 0, dv_count = 0, to_count = 0;
  int eoc_t = 0, dv_t = 0, to_t = 0, soc_fall_t = 0;
  logic last_eoc = 1'b1, last_soc = 1'b0;

  always @(negedge CLOCK) begin
    cyc = cyc + 1;
    if (ADC_SOC) soc_hi = soc_hi + 1;
    if (ADC_SOC && !last_soc) soc_pulses = soc_pulses + 1;
    if (!ADC_SOC && last_soc) soc_fall_t = cyc;
    if (!ADC_EOC_B && last_eoc) eoc_t = cyc;
    if (DATA_VALID) begin dv_count = dv_count + 1; dv_t = cyc; end
    if (TIMEOUT) begin to_count = to_count + 1; to_t = cyc; end
    last_eoc = ADC_EOC_B;
    last_soc = ADC_SOC;
  end

  task automatic clear_counts();
    @(posedge CLOCK);
    soc_hi = 0; soc_pulses = 0; dv_count = 0; to_count = 0;
  endtask

  task automatic pulse_start();
    @(negedge CLOCK); START = 1'b1;
    @(negedge CLOCK); START = 1'b0;
  endtask

  task automatic wait_dv(input int bound, output bit got, output logic [11:0] d);
    got = 1'b0; d = 12'h000;
    for (int i = 0; i < bound; i++) begin
      @(negedge CLOCK);
      if (DATA_VALID) begin got = 1'b1; d = DATA; break; end
    end
  endtask

  task automatic wait_soc_low(input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge CLOCK);
      if (!ADC_SOC) break;
    end
  endtask

  task automatic test_reset();
    RESET_B = 1'b0;
    repeat (3) @(negedge CLOCK);
    total++; if (ADC_SOC !== 1'b0) begin bad++; $display("FAIL reset_soc got=%b want=0", ADC_SOC); end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", BUSY); end
    total++; if (DATA !== 12'h000) begin bad++; $display("FAIL reset_data got=%h want=000", DATA); end
    total++; if (DATA_VALID !== 1'b0) begin bad++; $display("FAIL reset_dv got=%b want=0", DATA_VALID); end
    total++; if (TIMEOUT !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b want=0", TIMEOUT); end
    RESET_B = 1'b1;
  endtask

  task automatic test_single();
    bit got; logic [11:0] d;
    vals[0] = 12'hA5C; vidx = 0; adc_respond = 1'b1;
    clear_counts();
    @(negedge CLOCK); START = 1'b1;
    @(negedge CLOCK); START = 1'b0;
    total++; if (ADC_SOC !== 1'b1) begin bad++; $display("FAIL single_soc_start got=%b want=1", ADC_SOC); end
    total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL single_busy got=%b want=1", BUSY); end
    wait_dv(400, got, d);
    total++; if (got !== 1'b1) begin bad++; $display("FAIL single_dv_seen got=%b want=1", got); end
    total++; if (d !== 12'hA5C) begin bad++; $display("FAIL single_data got=%h want=a5c", d); end
    @(posedge CLOCK);
    total++; if (soc_hi !== 64) begin bad++; $display("FAIL single_soc_len got=%0d want=64", soc_hi); end
    total++; if (soc_pulses !== 1) begin bad++; $display("FAIL single_soc_pulses got=%0d want=1", soc_pulses); end
    total++; if (dv_count !== 1) begin bad++; $display("FAIL single_dv_count got=%0d want=1", dv_count); end
    // EOC low -> 2 sync edges -> SETTLE(2)+3 edges to DATA_VALID
    total++; if (dv_t - eoc_t !== 7) begin bad++; $display("FAIL single_latency got=%0d want=7", dv_t - eoc_t); end
    @(negedge CLOCK);
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL single_busy_after got=%b want=0", BUSY); end
  endtask

  task automatic test_timeout();
    bit got;
    adc_respond = 1'b0;
    clear_counts();
    pulse_start();
    got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLOCK);
      if (TIMEOUT) begin got = 1'b1; break; end
    end
    @(posedge CLOCK);
    total++; if (got !== 1'b1) begin bad++; $display("FAIL to_seen got=%b want=1", got); end
    total++; if (to_t - soc_fall_t !== 100) begin bad++; $display("FAIL to_delay got=%0d want=100", to_t - soc_fall_t); end
    total++; if (to_count !== 1) begin bad++; $display("FAIL to_count got=%0d want=1", to_count); end
    total++; if (dv_count !== 0) begin bad++; $display("FAIL to_no_dv got=%0d want=0", dv_count); end
    total++; if (DATA !== 12'hA5C) begin bad++; $display("FAIL to_data_kept got=%h want=a5c", DATA); end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL to_busy got=%b want=0", BUSY); end
  endtask

  task automatic test_busy_start();
    bit got; logic [11:0] d;
    vals[0] = 12'h123; vidx = 0; adc_respond = 1'b1;
    clear_counts();
    pulse_start();
    repeat (10) @(negedge CLOCK);
    START = 1'b1; @(negedge CLOCK); START = 1'b0;
    wait_soc_low(100);
    START = 1'b1; @(negedge CLOCK); START = 1'b0;
    wait_dv(300, got, d);
    repeat (100) @(negedge CLOCK);
    @(posedge CLOCK);
    total++; if (got !== 1'b1) begin bad++; $display("FAIL busy_dv_seen got=%b want=1", got); end
    total++; if (d !== 12'h123) begin bad++; $display("FAIL busy_data got=%h want=123", d); end
    total++; if (soc_pulses !== 1) begin bad++; $display("FAIL busy_soc_pulses got=%0d want=1", soc_pulses); end
    total++; if (dv_count !== 1) begin bad++; $display("FAIL busy_dv_count got=%0d want=1", dv_count); end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL busy_idle got=%b want=0", BUSY); end
  endtask

  task automatic test_avg();
    bit got; logic [11:0] d;
    vals[0] = 12'd100; vals[1] = 12'd101; vals[2] = 12'd102; vals[3] = 12'd103;
    vidx = 0; adc_respond = 1'b1;
    AVG_SEL = 2'd2;
    clear_counts();
    pulse_start();
    repeat (5) @(negedge CLOCK);
    AVG_SEL = 2'd0;  // must not affect the running request
    wait_dv(2000, got, d);
    @(posedge CLOCK);
    total++; if (got !== 1'b1) begin bad++; $display("FAIL avg_dv_seen got=%b want=1", got); end
    total++; if (d !== AVG_DATA) begin bad++; $display("FAIL avg_data got=%0d want=%0d", d, AVG_DATA); end
    total++; if (soc_pulses !== AVG_PULSES) begin bad++; $display("FAIL avg_soc_pulses got=%0d want=%0d", soc_pulses, AVG_PULSES); end
    total++; if (dv_count !== 1) begin bad++; $display("FAIL avg_dv_count got=%0d want=1", dv_count); end
  endtask

  task automatic test_reset_wait();
    bit got; logic [11:0] d;
    adc_respond = 1'b0;
    pulse_start();
    wait_soc_low(100);
    repeat (5) @(negedge CLOCK);
    RESET_B = 1'b0;
    @(negedge CLOCK);
    total++; if (ADC_SOC !== 1'b0) begin bad++; $display("FAIL rstw_soc got=%b want=0", ADC_SOC); end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL rstw_busy got=%b want=0", BUSY); end
    total++; if (DATA !== 12'h000) begin bad++; $display("FAIL rstw_data got=%h want=000", DATA); end
    total++; if (DATA_VALID !== 1'b0) begin bad++; $display("FAIL rstw_dv got=%b want=0", DATA_VALID); end
    RESET_B = 1'b1;
    vals[0] = 12'h3C7; vidx = 0; adc_respond = 1'b1;
    clear_counts();
    pulse_start();
    wait_dv(400, got, d);
    @(posedge CLOCK);
    total++; if (got !== 1'b1) begin bad++; $display("FAIL rstw_dv_seen got=%b want=1", got); end
    total++; if (d !== 12'h3C7) begin bad++; $display("FAIL rstw_data_after got=%h want=3c7", d); end
    total++; if (dv_count !== 1) begin bad++; $display("FAIL rstw_dv_count got=%0d want=1", dv_count); end
  endtask

  task automatic test_back_to_back();
    bit got1, got2; logic [11:0] d1, d2; logic busy_at_dv;
    vals[0] = 12'h111; vals[1] = 12'h222; vidx = 0; adc_respond = 1'b1;
    AVG_SEL = 2'd0;
    clear_counts();
    @(negedge CLOCK); START = 1'b1;
    wait_dv(400, got1, d1);
    busy_at_dv = BUSY;
    START = 1'b0;
    wait_dv(400, got2, d2);
    @(posedge CLOCK);
    total++; if (got1 !== 1'b1) begin bad++; $display("FAIL b2b_dv1_seen got=%b want=1", got1); end
    total++; if (d1 !== 12'h111) begin bad++; $display("FAIL b2b_data1 got=%h want=111", d1); end
    total++; if (busy_at_dv !== 1'b1) begin bad++; $display("FAIL b2b_restart got=%b want=1", busy_at_dv); end
    total++; if (got2 !== 1'b1) begin bad++; $display("FAIL b2b_dv2_seen got=%b want=1", got2); end
    total++; if (d2 !== 12'h222) begin bad++; $display("FAIL b2b_data2 got=%h want=222", d2); end
    total++; if (soc_pulses !== 2) begin bad++; $display("FAIL b2b_soc_pulses got=%0d want=2", soc_pulses); end
    total++; if (dv_count !== 2) begin bad++; $display("FAIL b2b_dv_count got=%0d want=2", dv_count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_timeout();
    test_busy_start();
    test_avg();
    test_reset_wait();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
